smg_scan_module: RTL and testbench
==================================

Name: smg_scan_module

Overview:
- Upstream driver for the 7-segment encoder in the whack-a-mole display path.
- Holds a frame of NUM_DIGITS 4-bit display codes: 0-9 digits, 10-14 = L/E/V/A/d, 15 = dash.
- Time-multiplexes the codes onto the encoder's Number_Data input and drives the active-low digit-select lines.
- Digit select is delayed to line up with the encoder's one-cycle registered output.
- Frame updates are tear-free: staged and applied only at frame start.

Parameters:
- NUM_DIGITS, 6: number of multiplexed digits; legal range 2..8.
- SCAN_DIV, 50000: clk cycles each digit stays selected; must be at least 4.
- CNT_W, 16: width of the divide counter; must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
- clk  in  1: system clock; every register is rising-edge.
- rst_n  in  1: asynchronous, active-low reset.
- disp_word  in  4*NUM_DIGITS: frame codes; nibble i belongs to digit i; digit 0 is the rightmost (least significant).
- disp_load  in  1: single-cycle strobe that captures disp_word.
- Number_Data  out  4: code for the currently scanned digit, fed to the encoder.
- SMG_Scan  out  NUM_DIGITS: active-low digit enables, aligned with the encoder's SMG_Data.
- frame_start  out  1: one-cycle pulse when the scan wraps to digit 0 and the shadow register updates.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - div_cnt = 0, digit_idx = 0.
  - shadow = all nibbles 4'hF (dashes).
  - pending = 0, pend_vld = 0.
  - Number_Data = 4'hF.
  - SMG_Scan = all ones (every digit off); scan pipeline stages = all ones.
  - frame_start = 0.
- Divider:
  - div_cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - tick is asserted when div_cnt == SCAN_DIV-1.
- Digit index:
  - On tick, digit_idx increments.
  - At NUM_DIGITS-1 it wraps to 0; the wrap is the frame boundary.
- Staging:
  - disp_load = 1 sets pending <= disp_word and pend_vld <= 1.
  - A later load before the boundary overwrites pending; last load wins.
- Frame boundary (the cycle tick occurs while digit_idx == NUM_DIGITS-1):
  - If pend_vld = 1: shadow <= pending, pend_vld <= 0.
  - If disp_load = 1 in that same cycle: disp_word bypasses pending, goes straight into shadow, and pend_vld ends at 0.
  - frame_start pulses high in the following cycle, while digit_idx == 0.
- Data stage:
  - Number_Data <= shadow[digit_idx] every cycle (registered, one cycle after digit_idx).
  - The shadow update and the digit_idx change at the boundary take effect together, so digit 0 of a new frame always shows new data.
- Select stage:
  - sel0 <= ~onehot(digit_idx); SMG_Scan <= sel0 (two registers).
  - SMG_Scan therefore changes in the same cycle the encoder's SMG_Data reflects the new Number_Data.
  - Total latency from a digit_idx change to an SMG_Scan change is 2 cycles.
- Exactly one bit of SMG_Scan is low at any time after the first two post-reset cycles.
- Reset asserted mid-frame: all state returns to reset values immediately, and any staged frame is discarded.
- disp_load held high for several cycles is legal; each cycle overwrites pending.
- No arithmetic beyond the counters; all comparisons are against constants.

Optional Feature:
- Macro: SMG_LZ_BLANK_EN.
- Defined: leading-zero suppression.
  - Scanning from the highest digit downward, every 4'h0 nibble above the highest non-zero nibble is blanked: its SMG_Scan bit stays high (off) for its slot.
  - Digit 0 is never blanked.
  - Nibbles 10-15 count as non-zero.
  - The blank mask is computed from shadow at the frame boundary and registered with it.
- Undefined: every digit is always lit, and zeros display as "0".

Decomposition:
- Shared package smg_pkg holds:
  - the code constants CODE_L=10, CODE_E=11, CODE_V=12, CODE_A=13, CODE_D=14, CODE_DASH=15;
  - the default NUM_DIGITS and SCAN_DIV.
- One natural sub-module: smg_scan_div, the divide counter producing tick.
- The frame staging and scan pipeline stay in the top module.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4):
1. Reset and release, no load -> Number_Data = 4'hF; SMG_Scan = 4'b1111 for 2 cycles, then 1110, 1101, 1011, 0111, each held 4 cycles, repeating.
2. Pulse disp_load with 16'h1234 during digit 2 -> remainder of the current frame shows dashes; after frame_start, digit 0 shows 4, digit 1 shows 3, digit 2 shows 2, digit 3 shows 1.
3. Load 16'hAAAA then 16'h5555 within one frame -> next frame shows only 5s; the A code never appears.
4. disp_load with 16'h9876 in the exact boundary cycle -> shadow takes 9876 immediately; Number_Data = 6 on the next cycle; pend_vld = 0.
5. Assert rst_n low mid-digit after a load is pending -> outputs go to reset values asynchronously; after release the frame still shows dashes.
6. SMG_LZ_BLANK_EN defined, load 16'h0070 -> digits 1 and 0 lit; digit 3 SMG_Scan bit held high during its slot. Load 16'h0000 -> only digit 0 lit.

Source files
------------

// File: rtl/smg_pkg.sv
// Shared display codes and default scan geometry for the 7-segment scan path.
package smg_pkg;

    localparam logic [3:0] CODE_L    = 4'd10;
    localparam logic [3:0] CODE_E    = 4'd11;
    localparam logic [3:0] CODE_V    = 4'd12;
    localparam logic [3:0] CODE_A    = 4'd13;
    localparam logic [3:0] CODE_D    = 4'd14;
    localparam logic [3:0] CODE_DASH = 4'd15;

    localparam int NUM_DIGITS_DEF = 6;
    localparam int SCAN_DIV_DEF   = 50000;

endpackage

// File: rtl/smg_scan_div.sv
// Free-running scan divider: counts 0..SCAN_DIV-1 and flags the last count with tick.
module smg_scan_div #(
    parameter int SCAN_DIV = smg_pkg::SCAN_DIV_DEF,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [CNT_W-1:0] div_cnt;

    assign tick = (div_cnt == CNT_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/smg_scan_module.sv
// Multiplexes a staged frame of 4-bit display codes onto the segment encoder with aligned digit selects.
// Optional leading-zero blanking is enabled by defining SMG_LZ_BLANK_EN.
module smg_scan_module
    import smg_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int SCAN_DIV   = SCAN_DIV_DEF,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] disp_word,
    input  logic                    disp_load,
    output logic [3:0]              Number_Data,
    output logic [NUM_DIGITS-1:0]   SMG_Scan,
    output logic                    frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic                    tick;
    logic                    boundary;
    logic                    frame_update;
    logic [IDX_W-1:0]        digit_idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] pending;
    logic [4*NUM_DIGITS-1:0] shadow_nxt;
    logic                    pend_vld;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [NUM_DIGITS-1:0]   sel_on;
    logic [NUM_DIGITS-1:0]   sel0;
    logic [3:0]              cur_code;

    smg_scan_div #(
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (CNT_W)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // A load in the boundary cycle bypasses pending so it is never lost.
    assign boundary     = tick && (digit_idx == LAST_IDX);
    assign shadow_nxt   = disp_load ? disp_word : pending;
    assign frame_update = boundary && (disp_load || pend_vld);

    always_comb begin
        cur_code = CODE_DASH;
        onehot   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_code  = shadow[i*4 +: 4];
                onehot[i] = 1'b1;
            end
        end
    end

`ifdef SMG_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] blank_mask;
    logic [NUM_DIGITS-1:0] blank_nxt;
    logic                  still_zero;

    // Digit 0 is excluded from the scan so a zero frame still shows "0".
    always_comb begin
        blank_nxt  = '0;
        still_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (still_zero && (shadow_nxt[i*4 +: 4] == 4'h0)) begin
                blank_nxt[i] = 1'b1;
            end else begin
                still_zero = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_mask <= '0;
        end else if (frame_update) begin
            blank_mask <= blank_nxt;
        end
    end

    assign sel_on = onehot & ~blank_mask;
`else
    assign sel_on = onehot;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_idx   <= '0;
            shadow      <= {NUM_DIGITS{CODE_DASH}};
            pending     <= '0;
            pend_vld    <= 1'b0;
            Number_Data <= CODE_DASH;
            sel0        <= '1;
            SMG_Scan    <= '1;
            frame_start <= 1'b0;
        end else begin
            if (tick) begin
                digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + IDX_W'(1);
            end
            if (boundary) begin
                if (frame_update) begin
                    shadow <= shadow_nxt;
                end
                pend_vld <= 1'b0;
            end else if (disp_load) begin
                pending  <= disp_word;
                pend_vld <= 1'b1;
            end
            frame_start <= boundary;
            Number_Data <= cur_code;
            // Two select stages keep SMG_Scan aligned with the encoder's registered segments.
            sel0        <= ~sel_on;
            SMG_Scan    <= sel0;
        end
    end

endmodule

// File: tb/tb_smg_scan_module.sv
// Randomized self-checking bench for smg_scan_module (NUM_DIGITS=4, SCAN_DIV=4); honours SMG_LZ_BLANK_EN.
module tb_smg_scan_module;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;

    logic        clk;
    logic        rst_n;
    logic [15:0] disp_word;
    logic        disp_load;
    logic [3:0]  Number_Data;
    logic [3:0]  SMG_Scan;
    logic        frame_start;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: c = rising edges since reset release; sh0/sh1/sh2 = frame after c, c-1, c-2 edges.
    int          c;
    logic [15:0] sh0, sh1, sh2, pend;
    bit          pv;

    smg_scan_module #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (DIV),
        .CNT_W      (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .disp_word   (disp_word),
        .disp_load   (disp_load),
        .Number_Data (Number_Data),
        .SMG_Scan    (SMG_Scan),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h, wanted %0h", tag, c, obs, exp);
        end
    endtask

    function automatic int idx_at(input int k);
        return (k / DIV) % N;
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] w, input int i);
        return w[i*4 +: 4];
    endfunction

    function automatic logic [3:0] lz_mask(input logic [15:0] w);
        logic [3:0] m;
        int hi;
        hi = 0;
        m  = 4'h0;
        for (int i = 0; i < N; i++) if (nib(w, i) != 4'h0) hi = i;
        for (int i = 1; i < N; i++) if (i > hi) m[i] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        c    = 0;
        sh0  = 16'hFFFF;
        sh1  = 16'hFFFF;
        sh2  = 16'hFFFF;
        pend = 16'h0000;
        pv   = 1'b0;
    endtask

    task automatic check_outputs();
        logic [3:0] exp_num, exp_scan, m;
        int d;
        exp_num  = (c < 1) ? 4'hF : nib(sh1, idx_at(c - 1));
        exp_scan = 4'hF;
        if (c >= 2) begin
            d = idx_at(c - 2);
            exp_scan[d] = 1'b0;
`ifdef SMG_LZ_BLANK_EN
            m = lz_mask(sh2);
            if (m[d]) exp_scan[d] = 1'b1;
`else
            m = 4'h0;
`endif
        end
        check("number_data", 32'(Number_Data), 32'(exp_num));
        check("smg_scan", 32'(SMG_Scan), 32'(exp_scan));
        check("frame_start", 32'(frame_start), 32'((c >= 1) && (c % FRAME == 0)));
        check("pend_vld", 32'(dut.pend_vld), 32'(pv));
    endtask

    task automatic step(input bit ld, input logic [15:0] w);
        logic [15:0] nxt;
        disp_load = ld;
        disp_word = w;
        @(posedge clk);
        nxt = sh0;
        if (c % FRAME == FRAME - 1) begin
            if (ld) nxt = w;
            else if (pv) nxt = pend;
            pv = 1'b0;
        end else if (ld) begin
            pend = w;
            pv   = 1'b1;
        end
        sh2 = sh1;
        sh1 = sh0;
        sh0 = nxt;
        c++;
        #1;
        disp_load = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 16'h0000);
    endtask

    task automatic run_to(input int ph);
        for (int k = 0; k < FRAME && (c % FRAME) != ph; k++) step(1'b0, 16'h0000);
    endtask

    initial begin
        logic [15:0] w;
        rst_n     = 1'b0;
        disp_load = 1'b0;
        disp_word = 16'h0000;
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();

        // Idle scan with dashes
        idle(40);

        // Load during digit 2, applied at the next frame
        run_to(8);
        step(1'b1, 16'h1234);
        idle(2 * FRAME);

        // Last load before the boundary wins
        run_to(2);
        step(1'b1, 16'hAAAA);
        idle(3);
        step(1'b1, 16'h5555);
        idle(2 * FRAME);

        // Load in the exact boundary cycle bypasses pending
        run_to(FRAME - 1);
        step(1'b1, 16'h9876);
        idle(FRAME + 4);

        // Async reset mid-digit discards a staged frame
        run_to(5);
        step(1'b1, 16'h4321);
        step(1'b0, 16'h0000);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2 * FRAME + 3);

        // Zero patterns (blanked when leading-zero suppression is built in)
        run_to(0);
        step(1'b1, 16'h0070);
        idle(2 * FRAME);
        step(1'b1, 16'h0000);
        idle(2 * FRAME);
        step(1'b1, 16'h0305);
        idle(2 * FRAME);

        // Random loads, including held strobes and words with leading zeros
        for (int k = 0; k < 500; k++) begin
            w = 16'($urandom) >> $urandom_range(0, 15);
            step($urandom_range(0, 5) == 0, w);
        end
        idle(2 * FRAME);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
